// File: rtl/control_parametros.sv
// control_parametros: button front end for the 7-segment setpoint display.
// Three raw push-buttons are synchronised, debounced and edge-detected into
// one-cycle press pulses. The pulses drive a two-mode setpoint controller
// (corriente / frecuencia). A free-running prescaler produces the digit-scan
// index used by the display decoder.
module control_parametros #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_modo,
  output logic       selector,
  output logic [9:0] corriente,
  output logic [7:0] frecuencia,
  output logic [1:0] cont,
  output logic       cambio
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Prescaler holds 0..SCAN_DIV-1; keep at least one bit when SCAN_DIV is 1.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  // Bit positions of the buttons inside the raw/press vectors.
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_MODE = 2;

  localparam logic [9:0] CORR_STEP = 10'd100;
  localparam logic [9:0] CORR_MAX  = 10'd1000;
  localparam logic [2:0] IDX_MAX   = 3'd7;

  typedef enum logic {
    MODO_FREC = 1'b0,
    MODO_CORR = 1'b1
  } modo_t;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {btn_modo, btn_abajo, btn_arriba};

  // ---------------------------------------------------------------------------
  // Per-button conditioning: synchroniser -> debouncer -> registered rising edge
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          level_d_reg;
      logic          pulse_reg;
      logic [CW-1:0] count_reg;

      // Two-flop synchroniser for the asynchronous button input.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          level_reg <= 1'b0;
          count_reg <= '0;
        end else if (sync2_reg == level_reg) begin
          count_reg <= '0;
        end else if (count_reg == CNT_LAST) begin
          level_reg <= ~level_reg;
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end

      // Registered rising-edge detector; releases never generate a pulse.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          level_d_reg <= 1'b0;
          pulse_reg   <= 1'b0;
        end else begin
          level_d_reg <= level_reg;
          pulse_reg   <= level_reg & ~level_d_reg;
        end
      end

      assign press[gi] = pulse_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Setpoint controller
  // ---------------------------------------------------------------------------
  modo_t      state_reg,     state_next;
  logic [9:0] corriente_reg, corriente_next;
  logic [2:0] idx_reg,       idx_next;
  logic [7:0] frec_reg,      frec_next;
  logic       cambio_reg,    cambio_next;
  logic       step_up;
  logic       step_down;

  // Frequency table indexed by the 3-bit frequency position.
  function automatic logic [7:0] frec_tabla(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0:    val = 8'd10;
      3'd1:    val = 8'd30;
      3'd2:    val = 8'd50;
      3'd3:    val = 8'd75;
      3'd4:    val = 8'd100;
      3'd5:    val = 8'd125;
      3'd6:    val = 8'd175;
      default: val = 8'd250;
    endcase
    return val;
  endfunction

  // A simultaneous up+down press cancels out; mode press masks both.
  assign step_up   = press[BTN_UP]   & ~press[BTN_DOWN] & ~press[BTN_MODE];
  assign step_down = press[BTN_DOWN] & ~press[BTN_UP]   & ~press[BTN_MODE];

  // Next-state logic: mode toggle or saturating step of the active setpoint.
  always_comb begin
    state_next     = state_reg;
    corriente_next = corriente_reg;
    idx_next       = idx_reg;
    cambio_next    = 1'b0;

    if (press[BTN_MODE]) begin
      state_next  = (state_reg == MODO_CORR) ? MODO_FREC : MODO_CORR;
      cambio_next = 1'b1;
    end else if (step_up) begin
      if (state_reg == MODO_CORR) begin
        if (corriente_reg < CORR_MAX) begin
          corriente_next = corriente_reg + CORR_STEP;
          cambio_next    = 1'b1;
        end
      end else begin
        if (idx_reg != IDX_MAX) begin
          idx_next    = idx_reg + 3'd1;
          cambio_next = 1'b1;
        end
      end
    end else if (step_down) begin
      if (state_reg == MODO_CORR) begin
        if (corriente_reg != 10'd0) begin
          corriente_next = corriente_reg - CORR_STEP;
          cambio_next    = 1'b1;
        end
      end else begin
        if (idx_reg != 3'd0) begin
          idx_next    = idx_reg - 3'd1;
          cambio_next = 1'b1;
        end
      end
    end

    // Table lookup feeds a register so frecuencia has no combinational path.
    frec_next = frec_tabla(idx_next);
  end

  // Setpoint state register; cambio updates on the same edge as the values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= MODO_CORR;
      corriente_reg <= 10'd0;
      idx_reg       <= 3'd0;
      frec_reg      <= 8'd10;
      cambio_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      corriente_reg <= corriente_next;
      idx_reg       <= idx_next;
      frec_reg      <= frec_next;
      cambio_reg    <= cambio_next;
    end
  end

  assign selector   = (state_reg == MODO_CORR);
  assign corriente  = corriente_reg;
  assign frecuencia = frec_reg;
  assign cambio     = cambio_reg;

  // ---------------------------------------------------------------------------
  // Digit-scan counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_reg;
  logic [1:0]    cont_reg;

  // Each cont value is held for SCAN_DIV cycles, then advances modulo 4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg  <= '0;
      cont_reg <= 2'd0;
    end else if (pre_reg == PRE_LAST) begin
      pre_reg  <= '0;
      cont_reg <= cont_reg + 2'd1;
    end else begin
      pre_reg  <= pre_reg + PW'(1);
    end
  end

  assign cont = cont_reg;

endmodule

// File: tb/tb_control_parametros.sv
// Testbench for control_parametros: directed scenarios plus randomized button
// activity, checked every cycle against a behavioural model of the button
// front end, setpoint rules and scan timing.
module tb_control_parametros;

  localparam int N  = 4;
  localparam int SD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_arriba = 1'b0;
  logic       btn_abajo = 1'b0;
  logic       btn_modo = 1'b0;
  logic       selector;
  logic [9:0] corriente;
  logic [7:0] frecuencia;
  logic [1:0] cont;
  logic       cambio;

  control_parametros #(
    .DEBOUNCE_CYCLES(N),
    .SCAN_DIV(SD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_arriba(btn_arriba),
    .btn_abajo(btn_abajo),
    .btn_modo(btn_modo),
    .selector(selector),
    .corriente(corriente),
    .frecuencia(frecuencia),
    .cont(cont),
    .cambio(cambio)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cambio_cnt = 0;

  int freq_tab[8] = '{10, 30, 50, 75, 100, 125, 175, 250};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each button: a history of samples seen after the 2-cycle synchroniser delay.
  // A level is accepted once the last N synchronised samples all disagree with
  // the current accepted level; an accepted 0->1 change yields a press that
  // takes effect two edges later.
  bit [15:0] m_hist[3];
  bit        m_lvl[3];
  bit [1:0]  m_pend[3];
  bit        m_sel;
  int        m_corr;
  int        m_idx;
  bit        m_cambio;
  int        m_edges;
  bit        model_valid = 1'b0;

  always @(posedge clk) begin
    bit raw[3];
    bit due[3];
    bit all_diff;
    int nv;
    raw[0] = btn_arriba;
    raw[1] = btn_abajo;
    raw[2] = btn_modo;
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0;
        m_lvl[b]  = 1'b0;
        m_pend[b] = '0;
      end
      m_sel = 1'b1; m_corr = 0; m_idx = 0; m_cambio = 1'b0; m_edges = 0;
      model_valid = 1'b1;
    end else begin
      for (int b = 0; b < 3; b++) begin
        due[b]    = m_pend[b][0];
        m_pend[b] = m_pend[b] >> 1;
        all_diff  = 1'b1;
        for (int j = 1; j <= N; j++)
          if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b] = ~m_lvl[b];
          if (m_lvl[b]) m_pend[b][1] = 1'b1;
        end
        m_hist[b] = {m_hist[b][14:0], raw[b]};
      end
      m_cambio = 1'b0;
      if (due[2]) begin
        m_sel = ~m_sel;
        m_cambio = 1'b1;
      end else if (due[0] != due[1]) begin
        if (m_sel) begin
          nv = due[0] ? m_corr + 100 : m_corr - 100;
          if (nv > 1000) nv = 1000;
          if (nv < 0) nv = 0;
          if (nv != m_corr) begin m_corr = nv; m_cambio = 1'b1; end
        end else begin
          nv = due[0] ? m_idx + 1 : m_idx - 1;
          if (nv > 7) nv = 7;
          if (nv < 0) nv = 0;
          if (nv != m_idx) begin m_idx = nv; m_cambio = 1'b1; end
        end
      end
      m_edges++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("selector",   selector,   m_sel);
      check("corriente",  corriente,  m_corr);
      check("frecuencia", frecuencia, freq_tab[m_idx]);
      check("cambio",     cambio,     m_cambio);
      check("cont",       cont,       (m_edges / SD) % 4);
    end
    if (cambio === 1'b1) cambio_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_arriba = v;
      1: btn_abajo  = v;
      default: btn_modo = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input int gap);
    set_btn(b, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  // Counts edges from the first edge sampling btn_arriba=1 to the corriente update.
  task automatic measure_up_latency(output int lat);
    logic [9:0] prev;
    prev = corriente;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (corriente != prev) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  int cont_exp[15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
  int corr_exp[11] = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 1000};
  int fup_exp[8]   = '{30, 50, 75, 100, 125, 175, 250, 250};
  int fdn_exp[8]   = '{175, 125, 100, 75, 50, 30, 10, 10};

  initial begin
    int lat;
    int snap;
    int mask;
    int hold;
    int gap;

    // Reset defaults
    @(negedge clk);
    check("rst_selector", selector, 1);
    check("rst_corriente", corriente, 0);
    check("rst_frecuencia", frecuencia, 10);
    check("rst_cont", cont, 0);
    check("rst_cambio", cambio, 0);
    rst_n = 1'b1;

    // Scan sequence from the reset edge onward
    for (int i = 0; i < 15; i++) begin
      check($sformatf("cont_seq%0d", i), cont, cont_exp[i]);
      @(negedge clk);
    end

    // Up presses in corriente mode, first one timed
    snap = cambio_cnt;
    btn_arriba = 1'b1;
    measure_up_latency(lat);
    check("latency_up", lat, 7);
    @(negedge clk);
    btn_arriba = 1'b0;
    repeat (10) @(negedge clk);
    check("corr_press0", corriente, corr_exp[0]);
    check("cambio_press0", cambio_cnt - snap, 1);
    for (int i = 1; i < 11; i++) begin
      snap = cambio_cnt;
      press(0, 6, 10);
      check($sformatf("corr_press%0d", i), corriente, corr_exp[i]);
      check($sformatf("cambio_press%0d", i), cambio_cnt - snap, (i == 10) ? 0 : 1);
    end

    // Short glitch is ignored
    snap = cambio_cnt;
    press(0, 3, 12);
    check("glitch_corr", corriente, 1000);
    check("glitch_cambio", cambio_cnt - snap, 0);

    // Mode toggle, frequency walk up and down
    snap = cambio_cnt;
    press(2, 6, 10);
    check("mode_selector", selector, 0);
    check("mode_cambio", cambio_cnt - snap, 1);
    for (int i = 0; i < 8; i++) begin
      press(0, 6, 10);
      check($sformatf("frec_up%0d", i), frecuencia, fup_exp[i]);
    end
    check("corr_retained", corriente, 1000);
    for (int i = 0; i < 8; i++) begin
      press(1, 6, 10);
      check($sformatf("frec_dn%0d", i), frecuencia, fdn_exp[i]);
    end

    // Simultaneous up+down cancels
    press(0, 6, 10);
    check("frec_before_conflict", frecuencia, 30);
    snap = cambio_cnt;
    btn_arriba = 1'b1;
    btn_abajo  = 1'b1;
    repeat (6) @(negedge clk);
    btn_arriba = 1'b0;
    btn_abajo  = 1'b0;
    repeat (10) @(negedge clk);
    check("conflict_frec", frecuencia, 30);
    check("conflict_cambio", cambio_cnt - snap, 0);

    // Up held across a reset pulse
    btn_arriba = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_selector", selector, 1);
    check("midrst_corriente", corriente, 0);
    check("midrst_frecuencia", frecuencia, 10);
    rst_n = 1'b1;
    measure_up_latency(lat);
    check("latency_after_rst", lat, 7);
    check("corr_after_rst", corriente, 100);
    @(negedge clk);
    btn_arriba = 1'b0;
    repeat (10) @(negedge clk);
    check("corr_after_rst_release", corriente, 100);

    // Randomized activity, checked by the per-cycle model comparison
    for (int it = 0; it < 80; it++) begin
      mask = $urandom_range(1, 7);
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(0, 12);
      btn_arriba = mask[0];
      btn_abajo  = mask[1];
      btn_modo   = mask[2];
      repeat (hold) @(negedge clk);
      btn_arriba = 1'b0;
      btn_abajo  = 1'b0;
      btn_modo   = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
